// File: rtl/xor_bit_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xor_bit_packer_if: bit-in / word-out handshake bundle for the packer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface xor_bit_packer_if #(
  parameter int WIDTH = 8
);
  localparam int c_LEN_W = $clog2(WIDTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               flush;
  logic               flush_ack;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [c_LEN_W-1:0] out_len;
  logic               out_parity;
  logic [15:0]        word_count;

  // Packer side
  modport slave (
    input  in_valid, in_bit, flush, out_ready,
    output in_ready, flush_ack, out_valid, out_data, out_len, out_parity, word_count
  );

  // Producer / consumer side
  modport master (
    output in_valid, in_bit, flush, out_ready,
    input  in_ready, flush_ack, out_valid, out_data, out_len, out_parity, word_count
  );
endinterface
`default_nettype wire

// File: rtl/xor_bit_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xor_bit_packer: packs the XOR bit stream into WIDTH-bit words with    |
// | length and parity, supports flushing partial words                    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module xor_bit_packer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  xor_bit_packer_if.slave    bus
);
  localparam int c_CNT_W = $clog2(WIDTH);
  localparam int c_LEN_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [c_LEN_W-1:0] r_out_len;
  logic               r_out_parity;
  logic               r_flush_ack;
  logic [15:0]        r_word_count;

  logic               w_slot_free;
  logic               w_last_slot;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_complete;
  logic               w_flush_take;
  logic               w_load;
  logic [c_LEN_W-1:0] w_n;
  logic [WIDTH-1:0]   w_acc_next;

  assign w_slot_free  = !r_out_valid || bus.out_ready;
  assign w_last_slot  = (r_cnt == c_CNT_W'(WIDTH - 1));
  assign w_in_ready   = !w_last_slot || w_slot_free;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_complete   = w_accept && w_last_slot;
  // n counts a bit accepted this very cycle so flush includes it
  assign w_n          = c_LEN_W'(r_cnt) + c_LEN_W'(w_accept);
  assign w_flush_take = bus.flush && w_slot_free && (w_n != '0);
  assign w_load       = w_complete || w_flush_take;

  generate
    if (MSB_FIRST) begin : g_msb_first
      // Shift-in keeps the valid bits right-aligned for partial words
      always_comb begin
        w_acc_next = r_acc;
        if (w_accept) begin
          w_acc_next = {r_acc[WIDTH-2:0], bus.in_bit};
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_acc_next = r_acc;
        if (w_accept) begin
          w_acc_next[r_cnt] = bus.in_bit;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_len    <= '0;
      r_out_parity <= 1'b0;
      r_flush_ack  <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_flush_ack <= w_flush_take;
      if (w_load) begin
        r_out_data   <= w_acc_next;
        r_out_len    <= w_n;
        r_out_parity <= ^w_acc_next;
        r_out_valid  <= 1'b1;
        r_acc        <= '0;
        r_cnt        <= '0;
        if (r_word_count != 16'hFFFF) begin
          r_word_count <= r_word_count + 16'd1;
        end
      end else begin
        if (w_accept) begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
        if (bus.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.flush_ack  = r_flush_ack;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_len    = r_out_len;
  assign bus.out_parity = r_out_parity;
  assign bus.word_count = r_word_count;
endmodule
`default_nettype wire
